// File: rtl/midori_share_codec.sv
// Mask/unmask front end for the 3-share masked Midori S-box: splits plain nibbles into Boolean
// shares, feeds PRNG randomness, recycles rs, and recombines the delayed output shares.
module midori_share_codec #(
  parameter int LATENCY = 3,
  parameter int WARMUP  = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        seed_load,
  input  logic [63:0] seed,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [3:0]  in_data,
  output logic [3:0]  sb_in1,
  output logic [3:0]  sb_in2,
  output logic [3:0]  sb_in3,
  output logic [44:0] sb_r,
  output logic [5:0]  sb_rs_in,
  input  logic [5:0]  sb_rs_out,
  input  logic [3:0]  sb_out1,
  input  logic [3:0]  sb_out2,
  input  logic [3:0]  sb_out3,
  output logic        out_valid,
  output logic [3:0]  out_data
);
  typedef enum logic [1:0] {ST_UNSEEDED, ST_WARM, ST_RUN} state_t;

  localparam logic [63:0] TAPS   = 64'hD800_0000_0000_0000;
  localparam logic [7:0]  WARM_N = 8'(WARMUP);

  state_t             state;
  logic [63:0]        prng;
  logic [7:0]         warm_cnt;
  logic [LATENCY-1:0] vld_sr;
  logic [5:0]         rs_reg;
  logic [3:0]         m1, m2;
  logic               accept;
  logic               unused_prng;

  // 64 Galois steps per clock so consecutive cycles see non-overlapping mask material
  function automatic logic [63:0] lfsr64(input logic [63:0] s);
    logic [63:0] v;
    v = s;
    for (int i = 0; i < 64; i++)
      v = v[0] ? ((v >> 1) ^ TAPS) : (v >> 1);
    return v;
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_UNSEEDED;
      prng     <= 64'h1;
      warm_cnt <= '0;
      vld_sr   <= '0;
      rs_reg   <= '0;
    end else if (seed_load) begin
      prng     <= (seed == 64'h0) ? 64'h1 : seed;
      state    <= (WARMUP == 0) ? ST_RUN : ST_WARM;
      warm_cnt <= '0;
      vld_sr   <= '0;
      rs_reg   <= '0;
    end else begin
      vld_sr <= LATENCY'({vld_sr, accept});
      if (state != ST_UNSEEDED) begin
        prng   <= lfsr64(prng);
        rs_reg <= sb_rs_out;
      end
      if (state == ST_WARM) begin
        warm_cnt <= warm_cnt + 8'd1;
        if (warm_cnt + 8'd1 >= WARM_N) state <= ST_RUN;
      end
    end
  end

  assign in_ready = (state == ST_RUN);
  assign accept   = in_valid & in_ready;
  assign m1       = prng[3:0];
  assign m2       = prng[7:4];
  assign sb_r     = prng[52:8];
  assign unused_prng = ^prng[63:53];

  // Idle cycles present fresh shares of zero rather than stale data
  assign sb_in1   = m1;
  assign sb_in2   = m2;
  assign sb_in3   = m1 ^ m2 ^ (accept ? in_data : 4'h0);
  assign sb_rs_in = rs_reg;

  assign out_valid = vld_sr[LATENCY-1];
  assign out_data  = out_valid ? (sb_out1 ^ sb_out2 ^ sb_out3) : 4'h0;
endmodule

// File: tb/tb_midori_share_codec.sv
// Bench for midori_share_codec: behavioural masked S-box stand-in plus a transaction-level model
// (seed timeline, PRNG value, expected-result queue) checked cycle by cycle.
module tb_midori_share_codec;
  localparam int LAT = 3;
  localparam int WU  = 2;

  logic        clk = 1'b0;
  logic        rst, seed_load, in_valid, in_ready, out_valid;
  logic [63:0] seed;
  logic [3:0]  in_data, sb_in1, sb_in2, sb_in3, out_data;
  logic [3:0]  sb_out1 = '0, sb_out2 = '0, sb_out3 = '0;
  logic [44:0] sb_r;
  logic [5:0]  sb_rs_in, sb_rs_out = '0;

  int n_checks = 0, n_errors = 0;

  midori_share_codec #(.LATENCY(LAT), .WARMUP(WU)) dut (
    .clk(clk), .rst(rst), .seed_load(seed_load), .seed(seed),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .sb_in1(sb_in1), .sb_in2(sb_in2), .sb_in3(sb_in3), .sb_r(sb_r),
    .sb_rs_in(sb_rs_in), .sb_rs_out(sb_rs_out),
    .sb_out1(sb_out1), .sb_out2(sb_out2), .sb_out3(sb_out3),
    .out_valid(out_valid), .out_data(out_data)
  );

  always #5 clk = ~clk;

  logic [3:0] SB [16] = '{4'hC,4'hA,4'hD,4'h3,4'hE,4'hB,4'hF,4'h7,
                          4'h8,4'h9,4'h1,4'h5,4'h0,4'h2,4'h4,4'h6};

  function automatic logic [63:0] step64(input logic [63:0] s);
    for (int i = 0; i < 64; i++) s = s[0] ? ((s >> 1) ^ 64'hD800_0000_0000_0000) : (s >> 1);
    return s;
  endfunction

  // Masked S-box stand-in: recombine, substitute, re-split with fresh randomness, 3 cycles deep
  logic [3:0] sx1 = '0, sx2 = '0, r1, r2;
  always @(posedge clk) begin
    r1 = 4'($urandom); r2 = 4'($urandom);
    sx1 <= SB[sb_in1 ^ sb_in2 ^ sb_in3];
    sx2 <= sx1;
    sb_out1 <= r1; sb_out2 <= r2; sb_out3 <= sx2 ^ r1 ^ r2;
    sb_rs_out <= 6'($urandom);
  end

  // Reference model
  typedef struct { int due; logic [3:0] d; } exp_t;
  exp_t        q[$];
  int          cyc = 0, seed_cyc = 0;
  bit          m_seeded = 0, exp_ready = 0, exp_valid = 0, rdy;
  logic [63:0] m_prng = 64'h1;
  logic [5:0]  m_rs = '0;
  logic [3:0]  exp_data = '0;
  always @(posedge clk) begin
    rdy = exp_ready;
    cyc++;
    if (rst) begin
      m_seeded = 0; m_prng = 64'h1; m_rs = '0; q.delete();
    end else if (seed_load) begin
      m_seeded = 1; seed_cyc = cyc; m_prng = (seed == 0) ? 64'h1 : seed; m_rs = '0; q.delete();
    end else begin
      if (in_valid && rdy) q.push_back('{cyc + LAT - 1, SB[in_data]});
      if (m_seeded) begin m_prng = step64(m_prng); m_rs = sb_rs_out; end
    end
    while (q.size() > 0 && q[0].due < cyc) void'(q.pop_front());
    exp_valid = (q.size() > 0 && q[0].due == cyc);
    exp_data  = exp_valid ? q[0].d : 4'h0;
    exp_ready = m_seeded && (cyc - seed_cyc >= WU);
  end

  task automatic step(input bit v, input logic [3:0] d, input bit sl);
    @(posedge clk); #1;
    in_valid = v; in_data = d; seed_load = sl;
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1; seed = '0;
    step(0, 0, 0); step(0, 0, 0);
    rst = 0;
    n_checks++;
    if ({in_ready, out_valid, out_data, sb_rs_in} !== 12'h0) begin
      n_errors++; $display("FAIL reset_state: rdy=%b ov=%b od=%h rs=%h want all 0", in_ready, out_valid, out_data, sb_rs_in);
    end
    for (int i = 0; i < 10; i++) begin
      step(1, 4'($urandom), 0);
      n_checks++;
      if (in_ready !== 1'b0 || out_valid !== 1'b0) begin
        n_errors++; $display("FAIL unseeded_idle: rdy=%b ov=%b want 0 0", in_ready, out_valid);
      end
      n_checks++;
      if (sb_r !== 45'h0 || sb_in1 !== 4'h1 || (sb_in1 ^ sb_in2 ^ sb_in3) !== 4'h0) begin
        n_errors++; $display("FAIL prng_frozen: r=%h in1=%h want r=0 in1=1, shares of 0", sb_r, sb_in1);
      end
    end
  endtask

  task automatic test_seed_warmup();
    bit want [3] = '{0, 0, 1};
    seed = 64'h0123_4567_89AB_CDEF;
    step(0, 0, 1);
    for (int i = 0; i < 3; i++) begin
      step(0, 0, 0);
      n_checks++;
      if (in_ready !== want[i] || in_ready !== exp_ready) begin
        n_errors++; $display("FAIL warmup_ready[%0d]: got %b want %b", i, in_ready, want[i]);
      end
      n_checks++;
      if (sb_r !== m_prng[52:8] || sb_in1 !== m_prng[3:0] || sb_in2 !== m_prng[7:4] || sb_rs_in !== m_rs) begin
        n_errors++; $display("FAIL warmup_prng: r=%h rs=%h want r=%h rs=%h", sb_r, sb_rs_in, m_prng[52:8], m_rs);
      end
    end
  endtask

  task automatic test_stream();
    logic [3:0] got[$];
    for (int i = 0; i < 16 + LAT + 1; i++) begin
      step(i < 16, 4'(i), 0);
      n_checks++;
      if (out_valid !== exp_valid || out_data !== exp_data) begin
        n_errors++; $display("FAIL stream_out: v=%b d=%h want v=%b d=%h", out_valid, out_data, exp_valid, exp_data);
      end
      if (out_valid) got.push_back(out_data);
    end
    n_checks++;
    if (got.size() != 16) begin
      n_errors++; $display("FAIL stream_count: got %0d want 16", got.size());
    end
    for (int i = 0; i < got.size() && i < 16; i++) begin
      n_checks++;
      if (got[i] !== SB[i]) begin
        n_errors++; $display("FAIL stream_sb0[%0d]: got %h want %h", i, got[i], SB[i]);
      end
    end
  endtask

  task automatic test_zero_seed();
    logic [44:0] tr1 [8], tr2 [8];
    bit nz;
    for (int pass = 0; pass < 2; pass++) begin
      seed = '0;
      step(0, 0, 1);
      step(0, 0, 0);
      n_checks++;
      if (sb_in1 !== 4'h1 || sb_r !== 45'h0) begin
        n_errors++; $display("FAIL zero_seed_load: in1=%h r=%h want 1 0", sb_in1, sb_r);
      end
      nz = 0;
      for (int i = 0; i < 8; i++) begin
        if (i > 0) step(0, 0, 0);
        if (pass == 0) tr1[i] = sb_r; else tr2[i] = sb_r;
        if (i < 4 && sb_r != 0) nz = 1;
        n_checks++;
        if (sb_r !== m_prng[52:8]) begin
          n_errors++; $display("FAIL zero_seed_prng[%0d]: got %h want %h", i, sb_r, m_prng[52:8]);
        end
      end
      n_checks++;
      if (!nz) begin
        n_errors++; $display("FAIL zero_seed_nonzero: sb_r stayed 0 for 4 cycles");
      end
    end
    for (int i = 0; i < 8; i++) begin
      n_checks++;
      if (tr1[i] !== tr2[i]) begin
        n_errors++; $display("FAIL reseed_repeat[%0d]: got %h want %h", i, tr2[i], tr1[i]);
      end
    end
  endtask

  task automatic test_midstream_reload();
    bit want_rdy [6] = '{0, 0, 1, 1, 1, 1};
    int n;
    n = 0;
    while (!in_ready && n < 10) begin step(0, 0, 0); n++; end
    n_checks++;
    if (!in_ready) begin
      n_errors++; $display("FAIL reload_wait: in_ready=%b want 1 within 10 cycles", in_ready);
    end
    step(1, 4'h5, 0);
    step(1, 4'hA, 0);
    seed = {$urandom, $urandom};
    step(0, 0, 1);
    for (int i = 0; i < 6; i++) begin
      step(0, 0, 0);
      n_checks++;
      if (out_valid !== 1'b0 || out_valid !== exp_valid) begin
        n_errors++; $display("FAIL reload_flush[%0d]: out_valid=%b want 0", i, out_valid);
      end
      n_checks++;
      if (in_ready !== want_rdy[i]) begin
        n_errors++; $display("FAIL reload_ready[%0d]: got %b want %b", i, in_ready, want_rdy[i]);
      end
    end
  endtask

  task automatic test_sweep();
    int sent, outs, masked, cycles;
    logic [3:0] d;
    bit v;
    sent = 0; outs = 0; masked = 0; cycles = 0;
    while ((sent < 1000 || q.size() > 0 || exp_valid) && cycles < 5000) begin
      v = (sent < 1000) && ($urandom_range(0, 3) != 0);
      d = 4'($urandom);
      step(v, d, 0);
      cycles++;
      if (v && in_ready) begin
        sent++;
        if (sb_in1 != d && sb_in2 != d) masked++;
      end
      n_checks++;
      if ((sb_in1 ^ sb_in2 ^ sb_in3) !== ((v && exp_ready) ? d : 4'h0) || sb_r !== m_prng[52:8] || sb_rs_in !== m_rs) begin
        n_errors++; $display("FAIL sweep_shares: xor=%h r=%h rs=%h want xor=%h r=%h rs=%h", sb_in1 ^ sb_in2 ^ sb_in3,
                             sb_r, sb_rs_in, (v && exp_ready) ? d : 4'h0, m_prng[52:8], m_rs);
      end
      n_checks++;
      if (out_valid !== exp_valid || out_data !== exp_data) begin
        n_errors++; $display("FAIL sweep_out: v=%b d=%h want v=%b d=%h", out_valid, out_data, exp_valid, exp_data);
      end
      if (out_valid) outs++;
    end
    n_checks++;
    if (sent != 1000 || outs != 1000) begin
      n_errors++; $display("FAIL sweep_count: sent=%0d outs=%0d want 1000 1000", sent, outs);
    end
    n_checks++;
    if (masked * 10 <= sent * 7) begin
      n_errors++; $display("FAIL sweep_masking: %0d of %0d masked, want >70%%", masked, sent);
    end
  endtask

  initial begin
    rst = 1; seed_load = 0; in_valid = 0; in_data = 0; seed = '0;
    test_reset();
    test_seed_warmup();
    test_stream();
    test_zero_seed();
    test_midstream_reload();
    test_sweep();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
